// File: rtl/cut_seq_pkg.sv
// rtl/cut_seq_pkg.sv - shared types, constants and next-state helpers for the CUT vector sequencer
package cut_seq_pkg;

    localparam int DEF_IN_W       = 12;
    localparam int DEF_OUT_W      = 8;
    localparam int DEF_SETTLE_CYC = 2;
    localparam int DEF_CNT_W      = 16;

    // x^12+x^6+x^4+x+1, right-shift Galois form
    localparam logic [11:0] LFSR_TAPS = 12'h829;
    localparam logic [15:0] MISR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } seq_state_t;

    function automatic logic [11:0] lfsr_next(input logic [11:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 12'h000);
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] cur, input logic [15:0] data);
        return ((cur >> 1) ^ (cur[0] ? MISR_TAPS : 16'h0000)) ^ data;
    endfunction

endpackage

// File: rtl/cut_lfsr_gen.sv
// rtl/cut_lfsr_gen.sv - stimulus register stepping as a binary counter or a Galois LFSR
module cut_lfsr_gen
    import cut_seq_pkg::*;
#(
    parameter int IN_W = DEF_IN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            advance,
    input  logic            mode,
    input  logic [IN_W-1:0] seed,
    output logic [IN_W-1:0] stim
);

    localparam logic [IN_W-1:0] TAPS = IN_W'(LFSR_TAPS);

    logic            lfsr_mode;
    logic [IN_W-1:0] stim_next;

    always_comb begin
        if (lfsr_mode)
            stim_next = (stim >> 1) ^ (stim[0] ? TAPS : '0);
        else
            stim_next = stim + IN_W'(1);
    end

    // mode is latched at load so the input may change freely mid-sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim      <= '0;
            lfsr_mode <= 1'b0;
        end else if (load) begin
            lfsr_mode <= mode;
            if (!mode)
                stim <= '0;
            else if (seed == '0)
                stim <= IN_W'(1);
            else
                stim <= seed;
        end else if (advance) begin
            stim <= stim_next;
        end
    end

endmodule

// File: rtl/cut_vector_sequencer.sv
// rtl/cut_vector_sequencer.sv - drives paired CUTs, compares responses, counts mismatches
// Optional MISR signature over resp_impl enabled by CUT_MISR_SIG_EN.
module cut_vector_sequencer
    import cut_seq_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [IN_W-1:0]  seed,
    input  logic [IN_W-1:0]  num_vec,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] resp_impl,
    input  logic [OUT_W-1:0] resp_gold,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mism_cnt,
    output logic             first_fail_vld,
    output logic [IN_W-1:0]  first_fail_vec,
    output logic [15:0]      signature
);

    localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [IN_W:0]     FULL_SWEEP  = {1'b1, {IN_W{1'b0}}};
    localparam logic [IN_W:0]     REM_ONE     = (IN_W+1)'(1);

    seq_state_t        state;
    logic [SCNT_W-1:0] settle_cnt;
    logic [IN_W:0]     remaining;

    logic              start_ok;
    logic              abort_ok;
    logic              is_mism;
    logic              last_vec;
    logic              gen_advance;
    logic [CNT_W-1:0]  mism_nxt;

    always_comb begin
        start_ok    = (state == ST_IDLE) && start;
        abort_ok    = abort && ((state == ST_APPLY) || (state == ST_SETTLE) ||
                                (state == ST_CAPTURE));
        is_mism     = (resp_impl != resp_gold);
        mism_nxt    = (is_mism && (mism_cnt != CNT_MAX)) ? mism_cnt + CNT_W'(1) : mism_cnt;
        last_vec    = (remaining == REM_ONE);
        gen_advance = (state == ST_CAPTURE) && !abort_ok && !last_vec;
    end

    cut_lfsr_gen #(
        .IN_W (IN_W)
    ) u_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (start_ok),
        .advance (gen_advance),
        .mode    (mode),
        .seed    (seed),
        .stim    (stim)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            settle_cnt     <= '0;
            remaining      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mism_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            done <= 1'b0;
            if (abort_ok) begin
                // counters and first-fail capture survive an abort for post-mortem
                state <= ST_IDLE;
                busy  <= 1'b0;
                pass  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            mism_cnt       <= '0;
                            first_fail_vld <= 1'b0;
                            first_fail_vec <= '0;
                            pass           <= 1'b0;
                            if (mode && (num_vec == '0)) begin
                                remaining <= '0;
                                state     <= ST_DONE;
                                done      <= 1'b1;
                                pass      <= 1'b1;
                            end else begin
                                remaining <= mode ? {1'b0, num_vec} : FULL_SWEEP;
                                state     <= ST_APPLY;
                                busy      <= 1'b1;
                            end
                        end
                    end
                    ST_APPLY: begin
                        settle_cnt <= SETTLE_LAST;
                        state      <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == '0)
                            state <= ST_CAPTURE;
                        else
                            settle_cnt <= settle_cnt - SCNT_W'(1);
                    end
                    ST_CAPTURE: begin
                        mism_cnt <= mism_nxt;
                        if (is_mism && !first_fail_vld) begin
                            first_fail_vld <= 1'b1;
                            first_fail_vec <= stim;
                        end
                        remaining <= remaining - REM_ONE;
                        if (last_vec) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (mism_nxt == '0);
                        end else begin
                            state <= ST_APPLY;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef CUT_MISR_SIG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            signature <= '0;
        else if (start_ok)
            signature <= '0;
        else if ((state == ST_CAPTURE) && !abort_ok)
            signature <= misr_next(signature, 16'(resp_impl));
    end
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_cut_vector_sequencer.sv
// tb/tb_cut_vector_sequencer.sv - randomized self-checking bench against a vector-list reference model
module tb_cut_vector_sequencer;
    import cut_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        mode;
    logic [11:0] seed;
    logic [11:0] num_vec;
    logic [11:0] stim;
    logic [7:0]  resp_impl;
    logic [7:0]  resp_gold;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] mism_cnt;
    logic        first_fail_vld;
    logic [11:0] first_fail_vec;
    logic [15:0] signature;

    int          errors = 0;
    int          checks = 0;

    logic [11:0] fail_vec [4];
    int          fail_n;
    logic [7:0]  fail_mask;
    logic [11:0] obs_stim [$];

    cut_vector_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .mode           (mode),
        .seed           (seed),
        .num_vec        (num_vec),
        .stim           (stim),
        .resp_impl      (resp_impl),
        .resp_gold      (resp_gold),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .mism_cnt       (mism_cnt),
        .first_fail_vld (first_fail_vld),
        .first_fail_vec (first_fail_vec),
        .signature      (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] impl_of(input logic [11:0] v);
        return v[7:0] ^ {v[11:8], v[11:8]} ^ 8'h5A;
    endfunction

    function automatic logic is_faulty(input logic [11:0] v);
        for (int i = 0; i < fail_n; i++)
            if (fail_vec[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    assign resp_impl = impl_of(stim);
    assign resp_gold = resp_impl ^ (is_faulty(stim) ? fail_mask : 8'h00);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_sweep(input string tag, input logic m, input logic [11:0] sd,
                             input logic [11:0] nv, input bit dup_start, input bit start_abort);
        logic [11:0] exp_list [$];
        logic [11:0] v;
        int          n;
        int          exp_mism;
        logic        exp_ffv;
        logic [11:0] exp_ffvec;
        logic [15:0] exp_sig;
        int          busy_n;
        int          cyc;
        int          stim_err;
        bit          seen_done;

        n = m ? int'(nv) : 4096;
        v = m ? ((sd == 12'h000) ? 12'h001 : sd) : 12'h000;
        for (int i = 0; i < n; i++) begin
            exp_list.push_back(v);
            v = m ? lfsr_next(v) : v + 12'h001;
        end
        exp_mism  = 0;
        exp_ffv   = 1'b0;
        exp_ffvec = 12'h000;
        exp_sig   = 16'h0000;
        foreach (exp_list[i]) begin
            if (is_faulty(exp_list[i])) begin
                exp_mism++;
                if (!exp_ffv) begin
                    exp_ffv   = 1'b1;
                    exp_ffvec = exp_list[i];
                end
            end
            exp_sig = misr_next(exp_sig, {8'h00, impl_of(exp_list[i])});
        end
`ifndef CUT_MISR_SIG_EN
        exp_sig = 16'h0000;
`endif
        if (exp_mism > 65535) exp_mism = 65535;

        obs_stim.delete();
        @(negedge clk);
        start = 1'b1; mode = m; seed = sd; num_vec = nv; abort = start_abort;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;

        busy_n = 0; cyc = 0; stim_err = 0; seen_done = 0;
        while (!seen_done && cyc < 4 * n + 20) begin
            @(negedge clk);
            cyc++;
            if (start) begin
                start = 1'b0;
                mode  = m;
            end
            if (busy) begin
                if (busy_n % 4 == 0) obs_stim.push_back(stim);
                if (busy_n / 4 >= n || stim !== exp_list[busy_n / 4]) stim_err++;
                busy_n++;
                if (dup_start && busy_n == 6) begin
                    start = 1'b1;
                    mode  = ~m;
                end
            end
            if (done) seen_done = 1;
        end
        start = 1'b0;
        mode  = m;

        check_eq({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        check_eq({tag, "_done_cycle"}, 32'(cyc), 32'(4 * n + 1));
        check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'(4 * n));
        check_eq({tag, "_stim_seq_errs"}, 32'(stim_err), 32'd0);
        check_eq({tag, "_pass"}, 32'(pass), 32'(exp_mism == 0));
        check_eq({tag, "_mism_cnt"}, 32'(mism_cnt), 32'(exp_mism));
        check_eq({tag, "_ff_vld"}, 32'(first_fail_vld), 32'(exp_ffv));
        check_eq({tag, "_ff_vec"}, 32'(first_fail_vec), 32'(exp_ffvec));
        check_eq({tag, "_signature"}, 32'(signature), 32'(exp_sig));
        @(negedge clk);
        check_eq({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    task automatic clear_faults();
        fail_n = 0;
        foreach (fail_vec[i]) fail_vec[i] = 12'h000;
    endtask

    initial begin
        int          done_hits;
        int          k;
        bit          seen;
        logic [11:0] sd;
        logic [11:0] nv;
        logic [11:0] v;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
        seed = 12'h000; num_vec = 12'h000; fail_mask = 8'h01;
        clear_faults();

        repeat (3) @(negedge clk);
        check_eq("rst_stim", 32'(stim), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_pass", 32'(pass), 32'd0);
        check_eq("rst_mism", 32'(mism_cnt), 32'd0);
        check_eq("rst_ffv", 32'(first_fail_vld), 32'd0);
        check_eq("rst_ffvec", 32'(first_fail_vec), 32'd0);
        check_eq("rst_sig", 32'(signature), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // exhaustive, matching circuits
        run_sweep("exh_clean", 1'b0, 12'h000, 12'h000, 0, 0);

        // exhaustive, bit0 faults at two vectors
        clear_faults();
        fail_n = 2; fail_vec[0] = 12'h005; fail_vec[1] = 12'h7FF; fail_mask = 8'h01;
        run_sweep("exh_fault", 1'b0, 12'h000, 12'h000, 0, 0);
        check_eq("exh_fault_lit_mism", 32'(mism_cnt), 32'd2);
        check_eq("exh_fault_lit_ffvec", 32'(first_fail_vec), 32'h005);

        // LFSR sequence from seed 1
        clear_faults();
        run_sweep("lfsr3", 1'b1, 12'h001, 12'd3, 0, 0);
        check_eq("lfsr3_n", 32'(obs_stim.size()), 32'd3);
        if (obs_stim.size() == 3) begin
            check_eq("lfsr3_v0", 32'(obs_stim[0]), 32'h001);
            check_eq("lfsr3_v1", 32'(obs_stim[1]), 32'h829);
            check_eq("lfsr3_v2", 32'(obs_stim[2]), 32'hC3D);
        end

        // zero-length sweep and zero seed
        run_sweep("nv0", 1'b1, 12'h000, 12'd0, 0, 0);
        run_sweep("seed0", 1'b1, 12'h000, 12'd2, 0, 0);
        check_eq("seed0_first", 32'(obs_stim.size() > 0 ? obs_stim[0] : 12'hFFF), 32'h001);

        // randomized LFSR sweeps with faults planted on the trajectory
        for (int r = 0; r < 6; r++) begin
            sd = 12'($urandom);
            nv = 12'($urandom_range(1, 120));
            clear_faults();
            fail_n    = $urandom_range(0, 3);
            fail_mask = 8'($urandom_range(1, 255));
            for (int j = 0; j < fail_n; j++) begin
                v = (sd == 12'h000) ? 12'h001 : sd;
                k = $urandom_range(0, int'(nv) - 1);
                for (int s = 0; s < k; s++) v = lfsr_next(v);
                fail_vec[j] = v;
            end
            run_sweep($sformatf("rnd%0d", r), 1'b1, sd, nv, r == 1, r == 2);
        end

        // abort on busy cycle 10 of a mismatching exhaustive sweep
        clear_faults();
        fail_n = 2; fail_vec[0] = 12'h000; fail_vec[1] = 12'h001;
        fail_mask = 8'($urandom_range(1, 255));
        @(negedge clk);
        start = 1'b1; mode = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("abort_busy_before", 32'(busy), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_pass", 32'(pass), 32'd0);
        check_eq("abort_mism", 32'(mism_cnt), 32'd2);
        check_eq("abort_ffv", 32'(first_fail_vld), 32'd1);
        check_eq("abort_ffvec", 32'(first_fail_vec), 32'h000);
        done_hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) done_hits++;
        end
        check_eq("abort_no_done", 32'(done_hits), 32'd0);
        clear_faults();
        start = 1'b1; mode = 1'b1; seed = 12'h001; num_vec = 12'd1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_eq("restart_mism_clr", 32'(mism_cnt), 32'd0);
        check_eq("restart_ffv_clr", 32'(first_fail_vld), 32'd0);
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check_eq("restart_done", 32'(seen), 32'd1);

        // asynchronous reset in the middle of SETTLE
        fail_n = 1; fail_vec[0] = 12'h000; fail_mask = 8'h01;
        @(negedge clk);
        start = 1'b1; mode = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("mid_mism", 32'(mism_cnt), 32'd1);
        check_eq("mid_stim", 32'(stim), 32'h001);
        #2 rst_n = 1'b0; start = 1'b1;
        #1;
        check_eq("arst_stim", 32'(stim), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_mism", 32'(mism_cnt), 32'd0);
        check_eq("arst_ffv", 32'(first_fail_vld), 32'd0);
        check_eq("arst_ffvec", 32'(first_fail_vec), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("arst_hold_busy", 32'(busy), 32'd0);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check_eq("arst_idle_busy", 32'(busy), 32'd0);
        check_eq("arst_idle_pass", 32'(pass), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cut_vector_sequencer.md
Name: cut_vector_sequencer

Overview:
- Self-checking stimulus controller for the 12-input / 8-output combinational test circuits in this codebase.
- Drives input vectors to two circuit instances (implementation, golden), waits a settle window, and captures and compares both responses.
- Counts mismatches and records the first failing vector. Sits between the bench/top-level control and the paired combinational netlists for equivalence sweeps.

Parameters:
IN_W, 12, stimulus width (circuit input count)
OUT_W, 8, response width (circuit output count)
SETTLE_CYC, 2, cycles stim is held before capture (>=1)
CNT_W, 16, mismatch counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sweep; sampled only in IDLE
abort  in  1  stop sweep, return to IDLE
mode  in  1  0 = exhaustive counter, 1 = LFSR
seed  in  IN_W  LFSR start value (mode 1)
num_vec  in  IN_W  vectors to apply in mode 1
stim  out  IN_W  vector driven to both circuits
resp_impl  in  OUT_W  implementation circuit outputs
resp_gold  in  OUT_W  golden circuit outputs
busy  out  1  high in APPLY/SETTLE/CAPTURE
done  out  1  one-cycle pulse at sweep end
pass  out  1  sweep result, held until next start
mism_cnt  out  CNT_W  mismatch count, saturating
first_fail_vld  out  1  a failing vector was recorded
first_fail_vec  out  IN_W  stim of first mismatch
signature  out  16  MISR value (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; stim=0, busy=0, done=0, pass=0, mism_cnt=0, first_fail_vld=0, first_fail_vec=0, signature=0. Reset mid-sweep discards all progress.
- FSM states: IDLE, APPLY, SETTLE, CAPTURE, DONE.
- IDLE, start=1: clear mism_cnt, first_fail_*, and pass. Load stim with 0 (mode 0) or seed (mode 1; seed 0 is replaced by 1). Load the remaining count: 2^IN_W in mode 0, num_vec in mode 1. Go to APPLY. If mode 1 and num_vec=0, go directly to DONE with pass=1.
- APPLY: one cycle; stim is stable. Go to SETTLE.
- SETTLE: SETTLE_CYC cycles with stim held, then go to CAPTURE.
- CAPTURE: register resp_impl and resp_gold, then compare.
  - On mismatch: increment mism_cnt, saturating at all-ones.
  - If first_fail_vld=0, set first_fail_vld=1 and first_fail_vec=stim.
  - Decrement the remaining count. If it reaches 0, go to DONE. Otherwise advance stim and go to APPLY.
- Stim advance:
  - Mode 0: stim+1.
  - Mode 1: right-shift Galois LFSR: next = (stim>>1) ^ (stim[0] ? LFSR_TAPS : 0), with LFSR_TAPS=0x829 (polynomial x^12+x^6+x^4+x+1).
- Per-vector cost is SETTLE_CYC+2 cycles. Exhaustive sweep at defaults takes 4096*4 = 16384 cycles from APPLY to DONE.
- DONE: done=1 for one cycle; pass = (mism_cnt==0); go to IDLE.
- Mismatch count counts vectors, not bits.
- abort: takes priority over every other event in any busy state. Next cycle is IDLE, with no done pulse and pass=0; mism_cnt and first_fail_* are retained. abort in IDLE has no effect.
- start while busy is ignored. Simultaneous start and abort in IDLE: start wins.

Optional Feature:
- Macro: CUT_MISR_SIG_EN.
- Defined: 16-bit MISR (taps 0xB400) folds zero-extended resp_impl into signature on every CAPTURE. It clears on accepted start and holds after DONE.
- Undefined: no MISR logic; signature tied to 0.

Decomposition:
- Package cut_seq_pkg holds:
  - FSM state enum.
  - LFSR_TAPS and MISR_TAPS constants.
  - Default widths.
  - A pure function lfsr_next() shared with the bench model.
- One sub-module, cut_lfsr_gen: holds the stim register plus counter/LFSR next-state logic, with load/advance controls.
- The FSM, comparator and counters stay in the top.

Test Plan:
- Exhaustive, resp_gold=resp_impl -> done after 16384 busy cycles; pass=1, mism_cnt=0, first_fail_vld=0.
- Exhaustive, resp_gold differs by bit0 only when stim==0x005 or 0x7FF -> mism_cnt=2, first_fail_vec=0x005, pass=0.
- mode=1, seed=0x001, num_vec=3 -> stim sequence 0x001, 0x829, 0xC3D; done after 12 busy cycles.
- mode=1, seed=0, num_vec=0 -> done one cycle after start, pass=1; mode=1, seed=0 otherwise -> first stim=0x001.
- abort on cycle 10 of a mismatching sweep -> IDLE next cycle, no done, pass=0, mism_cnt retained; subsequent start clears it.
- rst_n pulsed low mid-SETTLE -> all outputs 0 immediately (async), FSM in IDLE; start=1 during reset ignored.
